// File: rtl/mem_port_arbiter.sv
// Single-port memory bus arbiter between instruction fetch and data load/store.
// One transaction in flight; data has priority, with a starvation guard for fetch and a response timeout.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT_CYC  = 255,
  parameter int DATA_W       = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [63:0]         if_req_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                mem_req_valid,
  output logic                mem_req_ready,
  input  logic [63:0]         mem_req_addr,
  input  logic                mem_req_wen,
  input  logic [DATA_W-1:0]   mem_req_wdata,
  input  logic [DATA_W/8-1:0] mem_req_wmask,
  output logic                mem_rsp_valid,
  output logic [DATA_W-1:0]   mem_rsp_data,
  output logic                bus_req_valid,
  input  logic                bus_req_ready,
  output logic [63:0]         bus_addr,
  output logic                bus_wen,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wmask,
  input  logic                bus_rsp_valid,
  input  logic [DATA_W-1:0]   bus_rsp_data,
  output logic                timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT_CYC - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  starve_cnt;
  logic [3:0]  starve_nxt;
  logic [7:0]  to_cnt;
  logic        owner_mem;
  logic        grant_if;
  logic        grant_mem;
  logic        accept;
  logic        req_done;
  logic        rsp_hit;
  logic        to_hit;
  logic [DATA_W-1:0] rsp_payload;

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    return (cnt == STARVE_MAX) ? cnt : cnt + 4'd1;
  endfunction

  // Writes and timeouts return zero data; reads pass the bus data through.
  function automatic logic [DATA_W-1:0] rsp_select(input logic zero, input logic [DATA_W-1:0] data);
    return zero ? '0 : data;
  endfunction

  always_comb begin
    grant_if  = if_req_valid && (!mem_req_valid || (starve_cnt == STARVE_MAX));
    grant_mem = mem_req_valid && !grant_if;
  end

  assign accept   = (state == S_IDLE) && (grant_if || grant_mem);
  assign req_done = (state == S_REQ) && bus_req_ready;
  assign rsp_hit  = (state == S_WAIT) && bus_rsp_valid;
  assign to_hit   = (state == S_WAIT) && !bus_rsp_valid && (to_cnt == TO_LAST);

  always_comb begin
    if (grant_if) begin
      starve_nxt = 4'd0;
    end else if (if_req_valid) begin
      starve_nxt = sat_inc(starve_cnt);
    end else begin
      starve_nxt = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_REQ;
      S_REQ:  if (bus_req_ready) state_nxt = S_WAIT;
      S_WAIT: if (rsp_hit || to_hit) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Readies are masked by rst so they drop in the same cycle reset is raised.
  always_comb begin
    if_req_ready  = 1'b0;
    mem_req_ready = 1'b0;
    bus_req_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if_req_ready  = grant_if && !rst;
        mem_req_ready = grant_mem && !rst;
      end
      S_REQ:   bus_req_valid = 1'b1;
      default: ;
    endcase
  end

  // Request capture stage: winner fields held in the bus registers until the bus accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_mem  <= 1'b0;
      starve_cnt <= 4'd0;
      bus_addr   <= '0;
      bus_wen    <= 1'b0;
      bus_wdata  <= '0;
      bus_wmask  <= '0;
    end else if (accept) begin
      owner_mem  <= grant_mem;
      starve_cnt <= starve_nxt;
      bus_addr   <= grant_mem ? mem_req_addr : if_req_addr;
      bus_wen    <= grant_mem && mem_req_wen;
      bus_wdata  <= grant_mem ? mem_req_wdata : '0;
      bus_wmask  <= grant_mem ? mem_req_wmask : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= 8'd0;
    end else if (req_done) begin
      to_cnt <= 8'd0;
    end else if ((state == S_WAIT) && !rsp_hit && !to_hit) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end

  assign rsp_payload = rsp_select(to_hit || bus_wen, bus_rsp_data);

  // Response stage: one-cycle pulse to the owner, data held until that owner's next response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rsp_valid  <= 1'b0;
      mem_rsp_valid <= 1'b0;
      if_rsp_data   <= '0;
      mem_rsp_data  <= '0;
      timeout_err   <= 1'b0;
    end else begin
      if_rsp_valid  <= 1'b0;
      mem_rsp_valid <= 1'b0;
      timeout_err   <= 1'b0;
      if (rsp_hit || to_hit) begin
        timeout_err <= to_hit;
        if (owner_mem) begin
          mem_rsp_valid <= 1'b1;
          mem_rsp_data  <= rsp_payload;
        end else begin
          if_rsp_valid <= 1'b1;
          if_rsp_data  <= rsp_payload;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, reset-in-flight sequence and
// randomized transactions checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int SL = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_rsp_valid;
  logic [63:0] if_rsp_data;
  logic        mem_req_valid, mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        bus_req_valid, bus_req_ready;
  logic [63:0] bus_addr;
  logic        bus_wen;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wmask;
  logic        bus_rsp_valid;
  logic [63:0] bus_rsp_data;
  logic        timeout_err;

  mem_port_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT_CYC(TO), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_addr(bus_addr),
    .bus_wen(bus_wen), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          iv;
    bit          mv;
    bit          wen;
    logic [63:0] if_addr;
    logic [63:0] mem_addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
    int          ready_dly;
    int          rsp_dly;
    bit          exp_if_win;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model state: consecutive data wins while fetch waited, last data per port.
  int          model_starve = 0;
  logic [63:0] last_if_data = '0;
  logic [63:0] last_mem_data = '0;

  vec_t tbl [10];

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0b required=%0b", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit iv, input bit mv, input bit wen,
                              input logic [63:0] ia, input logic [63:0] ma,
                              input logic [63:0] wd, input logic [7:0] wm,
                              input logic [63:0] rd, input int rdy, input int rsp,
                              input bit eif);
    vec_t v;
    v.iv = iv; v.mv = mv; v.wen = wen; v.if_addr = ia; v.mem_addr = ma;
    v.wdata = wd; v.wmask = wm; v.rdata = rd; v.ready_dly = rdy; v.rsp_dly = rsp;
    v.exp_if_win = eif;
    return v;
  endfunction

  task automatic do_txn(input vec_t v);
    bit          tout;
    int          exp_idx;
    logic [63:0] exp_addr;
    logic [63:0] exp_data;
    @(posedge clk); #1;
    bus_rsp_valid = 1'b0;
    bus_req_ready = 1'b0;
    if_req_valid  = v.iv;
    if_req_addr   = v.if_addr;
    mem_req_valid = v.mv;
    mem_req_addr  = v.mem_addr;
    mem_req_wen   = v.wen;
    mem_req_wdata = v.wdata;
    mem_req_wmask = v.wmask;
    @(negedge clk);
    chk1("if_req_ready grant", if_req_ready, v.exp_if_win);
    chk1("mem_req_ready grant", mem_req_ready, !v.exp_if_win);
    chk1("bus_req_valid idle", bus_req_valid, 1'b0);
    chk1("rsp quiet at accept", if_rsp_valid | mem_rsp_valid | timeout_err, 1'b0);
    if (v.exp_if_win || !v.iv) model_starve = 0;
    else if (model_starve < 15) model_starve++;
    exp_addr = v.exp_if_win ? v.if_addr : v.mem_addr;

    @(posedge clk); #1;
    if (v.exp_if_win) if_req_valid = 1'b0;
    else mem_req_valid = 1'b0;
    for (int i = 0; i <= v.ready_dly; i++) begin
      bus_req_ready = (i == v.ready_dly);
      @(negedge clk);
      chk1("bus_req_valid req", bus_req_valid, 1'b1);
      chk64("bus_addr", bus_addr, exp_addr);
      chk1("bus_wen", bus_wen, v.exp_if_win ? 1'b0 : v.wen);
      chk64("bus_wmask", {56'd0, bus_wmask}, v.exp_if_win ? 64'd0 : {56'd0, v.wmask});
      if (!v.exp_if_win) chk64("bus_wdata", bus_wdata, v.wdata);
      chk1("no accept in req", if_req_ready | mem_req_ready, 1'b0);
      @(posedge clk); #1;
    end
    bus_req_ready = 1'b0;

    tout    = (v.rsp_dly >= TO);
    exp_idx = (tout ? TO - 1 : v.rsp_dly) + 1;
    for (int c = 0; c <= exp_idx; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      bus_rsp_valid = (c == v.rsp_dly) || (tout && c == exp_idx);
      bus_rsp_data  = v.rdata;
      if (c == exp_idx) begin
        if_req_valid  = 1'b0;
        mem_req_valid = 1'b0;
      end
      @(negedge clk);
      if (c < exp_idx) begin
        chk1("rsp early", if_rsp_valid | mem_rsp_valid | timeout_err, 1'b0);
        chk1("no accept in wait", if_req_ready | mem_req_ready | bus_req_valid, 1'b0);
      end else begin
        exp_data = (tout || (!v.exp_if_win && v.wen)) ? 64'd0 : v.rdata;
        chk1("timeout_err", timeout_err, tout);
        if (v.exp_if_win) begin
          chk1("if_rsp_valid", if_rsp_valid, 1'b1);
          chk1("mem_rsp_valid quiet", mem_rsp_valid, 1'b0);
          chk64("if_rsp_data", if_rsp_data, exp_data);
          chk64("mem_rsp_data held", mem_rsp_data, last_mem_data);
          last_if_data = exp_data;
        end else begin
          chk1("mem_rsp_valid", mem_rsp_valid, 1'b1);
          chk1("if_rsp_valid quiet", if_rsp_valid, 1'b0);
          chk64("mem_rsp_data", mem_rsp_data, exp_data);
          chk64("if_rsp_data held", if_rsp_data, last_if_data);
          last_mem_data = exp_data;
        end
      end
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    v.iv = 1'($urandom_range(0, 1));
    v.mv = 1'($urandom_range(0, 1));
    if (!v.iv && !v.mv) v.mv = 1'b1;
    v.wen       = 1'($urandom_range(0, 1));
    v.if_addr   = {$urandom, $urandom};
    v.mem_addr  = {$urandom, $urandom};
    v.wdata     = {$urandom, $urandom};
    v.wmask     = 8'($urandom_range(0, 255));
    v.rdata     = {$urandom, $urandom};
    v.ready_dly = $urandom_range(0, 3);
    v.rsp_dly   = $urandom_range(0, TO + 1);
    v.exp_if_win = v.iv && (!v.mv || model_starve == SL);
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: actual=hang required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    if_req_valid = 1'b0; if_req_addr = '0;
    mem_req_valid = 1'b0; mem_req_addr = '0; mem_req_wen = 1'b0;
    mem_req_wdata = '0; mem_req_wmask = '0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_data = '0;

    tbl[0] = mk(1, 0, 0, 64'h8000_0000, 64'h0, 64'h0, 8'h00, 64'h13, 0, 0, 1);
    tbl[1] = mk(1, 1, 0, 64'h8000_0100, 64'h9000_0000, 64'h0, 8'h00, 64'h101, 0, 0, 0);
    tbl[2] = mk(1, 1, 1, 64'h8000_0108, 64'h9000_0008, 64'h1234, 8'hFF, 64'h102, 1, 2, 0);
    tbl[3] = mk(1, 1, 0, 64'h8000_0110, 64'h9000_0010, 64'h0, 8'h00, 64'h103, 0, 1, 0);
    tbl[4] = mk(1, 1, 0, 64'h8000_0118, 64'h9000_0018, 64'h0, 8'h00, 64'h104, 2, 0, 0);
    tbl[5] = mk(1, 1, 0, 64'h8000_0120, 64'h9000_0020, 64'h0, 8'h00, 64'h105, 0, 0, 1);
    tbl[6] = mk(1, 1, 0, 64'h8000_0128, 64'h9000_0028, 64'h0, 8'h00, 64'h106, 0, 0, 0);
    tbl[7] = mk(0, 1, 1, 64'h0, 64'h8000_1000, 64'hDEAD_BEEF, 8'h0F, 64'h5555, 3, 1, 0);
    tbl[8] = mk(0, 1, 0, 64'h0, 64'h8000_2000, 64'h0, 8'h00, 64'hAAAA, 0, 20, 0);
    tbl[9] = mk(1, 0, 0, 64'h8000_0040, 64'h0, 64'h0, 8'h00, 64'h77, 1, TO - 1, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("reset bus_req_valid", bus_req_valid, 1'b0);
    chk64("reset bus_addr", bus_addr, 64'd0);
    chk64("reset bus_wmask", {56'd0, bus_wmask}, 64'd0);
    chk1("reset bus_wen", bus_wen, 1'b0);
    chk1("reset rsp_valid", if_rsp_valid | mem_rsp_valid, 1'b0);
    chk64("reset rsp_data", if_rsp_data | mem_rsp_data, 64'd0);
    chk1("reset timeout_err", timeout_err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("idle no request ready", if_req_ready | mem_req_ready | bus_req_valid, 1'b0);

    for (int i = 0; i < 10; i++) do_txn(tbl[i]);

    // Reset raised while a data read sits in WAIT.
    @(posedge clk); #1;
    bus_rsp_valid = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 64'h8000_3000;
    mem_req_valid = 1'b1; mem_req_addr = 64'h8000_4000; mem_req_wen = 1'b0;
    @(negedge clk);
    chk1("pre-reset mem grant", mem_req_ready, model_starve != SL);
    @(posedge clk); #1;
    bus_req_ready = 1'b1;
    @(negedge clk);
    chk1("pre-reset bus_req_valid", bus_req_valid, 1'b1);
    @(posedge clk); #1;
    bus_req_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk1("rst bus_req_valid", bus_req_valid, 1'b0);
    chk1("rst readies", if_req_ready | mem_req_ready, 1'b0);
    chk1("rst rsp_valid", if_rsp_valid | mem_rsp_valid | timeout_err, 1'b0);
    chk64("rst rsp_data", if_rsp_data | mem_rsp_data, 64'd0);
    chk64("rst bus_addr", bus_addr, 64'd0);
    model_starve = 0;
    last_if_data = '0;
    last_mem_data = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    if_req_valid = 1'b0;
    mem_req_valid = 1'b0;

    for (int i = 0; i < 5; i++) begin
      vec_t v;
      v = mk(1, 1, 0, 64'h8000_5000 + 64'(i * 8), 64'h8000_6000 + 64'(i * 8), 64'h0, 8'h00,
             64'h200 + 64'(i), 0, 0, (i == SL));
      do_txn(v);
    end
    do_txn(mk(1, 0, 0, 64'h8000_7000, 64'h0, 64'h0, 8'h00, 64'h13, 0, 0, 1));

    for (int n = 0; n < 60; n++) do_txn(rand_vec());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
